// File: rtl/pci_read_target_if.sv
// Shared PCI bus signals between an initiator (master) and the read target (slave).
// All control signals are active-low, as on the real bus.
interface pci_read_target_if;
  logic        frame;
  logic        irdy;
  logic [3:0]  cbe;
  logic [31:0] ad_in;
  logic [31:0] ad_out;
  logic        ad_oe;
  logic        trdy;
  logic        devsel;
  logic        stop;

  modport master (
    output frame, irdy, cbe, ad_in,
    input  ad_out, ad_oe, trdy, devsel, stop
  );

  modport slave (
    input  frame, irdy, cbe, ad_in,
    output ad_out, ad_oe, trdy, devsel, stop
  );
endinterface

// File: rtl/pci_read_target.sv
// PCI target that claims memory reads inside its window and answers from a local word memory.
// Define PCI_TGT_DISCONNECT_EN to disconnect (STOP#) at the last word instead of wrapping.
module pci_read_target #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          MEM_WORDS   = 8,
  parameter int          WAIT_STATES = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  pci_read_target_if.slave             bus,
  input  logic                         wr_en,
  input  logic [$clog2(MEM_WORDS)-1:0] wr_addr,
  input  logic [31:0]                  wr_data
);
  localparam int            AW       = $clog2(MEM_WORDS);
  localparam logic [AW-1:0] LAST_IDX = AW'(MEM_WORDS - 1);
  localparam logic [1:0]    WS       = 2'(WAIT_STATES);
`ifdef PCI_TGT_DISCONNECT_EN
  localparam bit DISC_EN = 1'b1;
`else
  localparam bit DISC_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE, ST_TURN_IN, ST_WAIT, ST_DATA, ST_DISC, ST_TURN_OUT
  } state_t;

  logic [31:0]   mem [MEM_WORDS];
  state_t        state_reg;
  logic [AW-1:0] idx_reg;
  logic [1:0]    cnt_reg;
  logic          trdy_reg;
  logic          devsel_reg;
  logic          stop_reg;
  logic          ad_oe_reg;
  logic [31:0]   ad_out_reg;

  logic [AW-1:0] idx_inc;
  logic [AW-1:0] hit_idx;
  logic [31:0]   cur_word;
  logic [31:0]   nxt_word;
  logic          hit;
  logic          abandon;
  logic          last_word;
  logic          wait_done;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Backdoor data bypasses the array so a write to the presented word shows up next cycle.
  assign idx_inc   = idx_reg + AW'(1);
  assign cur_word  = (wr_en && wr_addr == idx_reg) ? wr_data : mem[idx_reg];
  assign nxt_word  = (wr_en && wr_addr == idx_inc) ? wr_data : mem[idx_inc];
  assign hit_idx   = bus.ad_in[AW+1:2];
  assign hit       = !bus.frame && bus.cbe == 4'b0110 && bus.ad_in[1:0] == 2'b00 &&
                     bus.ad_in[31:AW+2] == BASE_ADDR[31:AW+2];
  assign abandon   = bus.frame && bus.irdy;
  assign last_word = DISC_EN && idx_reg == LAST_IDX;
  assign wait_done = (state_reg == ST_TURN_IN && cnt_reg == 2'd0) ||
                     (state_reg == ST_WAIT && cnt_reg == 2'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      idx_reg    <= '0;
      cnt_reg    <= '0;
      trdy_reg   <= 1'b1;
      devsel_reg <= 1'b1;
      stop_reg   <= 1'b1;
      ad_oe_reg  <= 1'b0;
      ad_out_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (hit) begin
            idx_reg    <= hit_idx;
            cnt_reg    <= WS;
            devsel_reg <= 1'b0;
            state_reg  <= ST_TURN_IN;
          end
        end
        ST_TURN_IN, ST_WAIT: begin
          if (abandon) begin
            state_reg  <= ST_TURN_OUT;
            devsel_reg <= 1'b1;
            trdy_reg   <= 1'b1;
            stop_reg   <= 1'b1;
            ad_oe_reg  <= 1'b0;
          end else begin
            ad_oe_reg  <= 1'b1;
            ad_out_reg <= cur_word;
            if (state_reg == ST_WAIT) cnt_reg <= cnt_reg - 2'd1;
            if (wait_done) begin
              state_reg <= ST_DATA;
              trdy_reg  <= 1'b0;
              stop_reg  <= !(last_word && !bus.frame);
            end else begin
              state_reg <= ST_WAIT;
            end
          end
        end
        ST_DATA: begin
          if (!bus.irdy && !bus.frame && last_word) begin
            state_reg <= ST_DISC;
            trdy_reg  <= 1'b1;
            stop_reg  <= 1'b0;
            ad_oe_reg <= 1'b0;
          end else if (!bus.irdy && !bus.frame) begin
            idx_reg    <= idx_inc;
            cnt_reg    <= WS;
            ad_out_reg <= nxt_word;
            if (WS != 2'd0) begin
              state_reg <= ST_WAIT;
              trdy_reg  <= 1'b1;
              stop_reg  <= 1'b1;
            end else begin
              stop_reg <= !(DISC_EN && idx_inc == LAST_IDX);
            end
          end else if (bus.frame) begin
            // Last transfer (irdy low) or initiator abandon (irdy high).
            state_reg  <= ST_TURN_OUT;
            devsel_reg <= 1'b1;
            trdy_reg   <= 1'b1;
            stop_reg   <= 1'b1;
            ad_oe_reg  <= 1'b0;
          end else begin
            ad_out_reg <= cur_word;
          end
        end
        ST_DISC: begin
          if (bus.frame) begin
            state_reg  <= ST_TURN_OUT;
            devsel_reg <= 1'b1;
            trdy_reg   <= 1'b1;
            stop_reg   <= 1'b1;
            ad_oe_reg  <= 1'b0;
          end
        end
        ST_TURN_OUT: state_reg <= ST_IDLE;
        default:     state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.trdy   = trdy_reg;
  assign bus.devsel = devsel_reg;
  assign bus.stop   = stop_reg;
  assign bus.ad_oe  = ad_oe_reg;
  assign bus.ad_out = ad_out_reg;
endmodule
